// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters (A, B).
// A winner is picked in IDLE, its opcode/operands are latched and driven to the
// ALU for one EXEC cycle, and the registered ALU result comes back on a shared
// result bus with a per-requester valid pulse. One operation every two cycles.
// Optional build macro: ALU_ARB_OPCHK_EN enables illegal-opcode detection
// (opcodes 110/111 execute as ADD, return 0 and pulse err_x with rvalid_x).
module alu_share_arbiter #(
    parameter int WIDTH      = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [2:0]       sel_a,
    input  logic [WIDTH-1:0] opa_a,
    input  logic [WIDTH-1:0] opb_a,
    input  logic             req_b,
    input  logic [2:0]       sel_b,
    input  logic [WIDTH-1:0] opa_b,
    input  logic [WIDTH-1:0] opb_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic [2:0]       alusel,
    output logic [WIDTH-1:0] op1,
    output logic [WIDTH-1:0] op2,
    input  logic [WIDTH-1:0] aluout,
    output logic [WIDTH-1:0] result,
    output logic             rvalid_a,
    output logic             rvalid_b,
    output logic             busy,
    output logic             err_a,
    output logic             err_b
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EXEC = 1'b1;
    localparam logic [0:0] SIDE_A  = 1'b0;
    localparam logic [0:0] SIDE_B  = 1'b1;

    logic [0:0]       state_r;
    logic [0:0]       last_gnt_r;
    logic             gnt_a_r;
    logic             gnt_b_r;
    logic             busy_r;
    logic [2:0]       alusel_r;
    logic [WIDTH-1:0] op1_r;
    logic [WIDTH-1:0] op2_r;
    logic [WIDTH-1:0] result_r;
    logic             rvalid_a_r;
    logic             rvalid_b_r;

    logic             grant_a_s;
    logic             grant_b_s;
    logic [2:0]       win_sel_s;
    logic [2:0]       win_alusel_s;
    logic [WIDTH-1:0] win_opa_s;
    logic [WIDTH-1:0] win_opb_s;

`ifdef ALU_ARB_OPCHK_EN
    localparam logic [2:0] OP_ADD = 3'b011;

    logic illegal_r;
    logic err_a_r;
    logic err_b_r;
    logic win_illegal_s;

    // Opcodes 110 and 111 have no functional unit behind the result mux.
    function automatic logic opcode_illegal(input logic [2:0] sel);
        return (sel == 3'b110) || (sel == 3'b111);
    endfunction

    assign win_illegal_s = opcode_illegal(win_sel_s);
    // An illegal opcode still occupies the ALU, but with a harmless ADD selection.
    assign win_alusel_s  = win_illegal_s ? OP_ADD : win_sel_s;
    assign err_a         = err_a_r;
    assign err_b         = err_b_r;
`else
    assign win_alusel_s  = win_sel_s;
    assign err_a         = 1'b0;
    assign err_b         = 1'b0;
`endif

    // Arbitration: sole requester wins; a tie goes to A (fixed) or away from the last winner.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (req_a && req_b) begin
            if (FIXED_PRIO || (last_gnt_r == SIDE_B)) begin
                grant_a_s = 1'b1;
            end else begin
                grant_b_s = 1'b1;
            end
        end else if (req_a) begin
            grant_a_s = 1'b1;
        end else if (req_b) begin
            grant_b_s = 1'b1;
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    // Select the winning requester's opcode and operands for latching.
    always_comb begin
        if (grant_b_s) begin
            win_sel_s = sel_b;
            win_opa_s = opa_b;
            win_opb_s = opb_b;
        end else begin
            win_sel_s = sel_a;
            win_opa_s = opa_a;
            win_opb_s = opb_a;
        end
    end

    // Two-state sequencer: IDLE arbitrates and latches, EXEC captures the ALU result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            last_gnt_r <= SIDE_B;
            gnt_a_r    <= 1'b0;
            gnt_b_r    <= 1'b0;
            busy_r     <= 1'b0;
            alusel_r   <= 3'b000;
            op1_r      <= {WIDTH{1'b0}};
            op2_r      <= {WIDTH{1'b0}};
            result_r   <= {WIDTH{1'b0}};
            rvalid_a_r <= 1'b0;
            rvalid_b_r <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
            illegal_r  <= 1'b0;
            err_a_r    <= 1'b0;
            err_b_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rvalid_a_r <= 1'b0;
                    rvalid_b_r <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
                    err_a_r    <= 1'b0;
                    err_b_r    <= 1'b0;
`endif
                    if (grant_a_s || grant_b_s) begin
                        alusel_r   <= win_alusel_s;
                        op1_r      <= win_opa_s;
                        op2_r      <= win_opb_s;
`ifdef ALU_ARB_OPCHK_EN
                        illegal_r  <= win_illegal_s;
`endif
                        gnt_a_r    <= grant_a_s;
                        gnt_b_r    <= grant_b_s;
                        busy_r     <= 1'b1;
                        last_gnt_r <= grant_b_s ? SIDE_B : SIDE_A;
                        state_r    <= ST_EXEC;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
`ifdef ALU_ARB_OPCHK_EN
                    result_r   <= illegal_r ? {WIDTH{1'b0}} : aluout;
                    err_a_r    <= gnt_a_r & illegal_r;
                    err_b_r    <= gnt_b_r & illegal_r;
`else
                    result_r   <= aluout;
`endif
                    rvalid_a_r <= gnt_a_r;
                    rvalid_b_r <= gnt_b_r;
                    gnt_a_r    <= 1'b0;
                    gnt_b_r    <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    gnt_a_r    <= 1'b0;
                    gnt_b_r    <= 1'b0;
                    busy_r     <= 1'b0;
                    rvalid_a_r <= 1'b0;
                    rvalid_b_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_a    = gnt_a_r;
    assign gnt_b    = gnt_b_r;
    assign busy     = busy_r;
    assign alusel   = alusel_r;
    assign op1      = op1_r;
    assign op2      = op2_r;
    assign result   = result_r;
    assign rvalid_a = rvalid_a_r;
    assign rvalid_b = rvalid_b_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a round-robin instance (rr) and a fixed-priority
// instance (fp) share the same requester inputs; each has its own ALU model.
module tb_alu_share_arbiter;

    localparam int W = 32;
`ifdef ALU_ARB_OPCHK_EN
    localparam bit OPCHK = 1'b1;
`else
    localparam bit OPCHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         req_a, req_b;
    logic [2:0]   sel_a, sel_b;
    logic [W-1:0] opa_a, opb_a, opa_b, opb_b;

    logic         gnt_a_rr, gnt_b_rr, rvalid_a_rr, rvalid_b_rr, busy_rr, err_a_rr, err_b_rr;
    logic [2:0]   alusel_rr;
    logic [W-1:0] op1_rr, op2_rr, aluout_rr, result_rr;
    logic         gnt_a_fp, gnt_b_fp, rvalid_a_fp, rvalid_b_fp, busy_fp, err_a_fp, err_b_fp;
    logic [2:0]   alusel_fp;
    logic [W-1:0] op1_fp, op2_fp, aluout_fp, result_fp;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Reference ALU: AND, OR, SUB, ADD, logical left shift, arithmetic right shift.
    function automatic logic [W-1:0] alu_fn(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
        case (s)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a - b;
            3'd3:    return a + b;
            3'd4:    return a << b[4:0];
            3'd5:    return W'($signed(a) >>> b[4:0]);
            default: return {W{1'b0}};
        endcase
    endfunction

    assign aluout_rr = alu_fn(alusel_rr, op1_rr, op2_rr);
    assign aluout_fp = alu_fn(alusel_fp, op1_fp, op2_fp);

    alu_share_arbiter #(.WIDTH(W), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .sel_a(sel_a), .opa_a(opa_a), .opb_a(opb_a),
        .req_b(req_b), .sel_b(sel_b), .opa_b(opa_b), .opb_b(opb_b),
        .gnt_a(gnt_a_rr), .gnt_b(gnt_b_rr), .alusel(alusel_rr), .op1(op1_rr), .op2(op2_rr),
        .aluout(aluout_rr), .result(result_rr), .rvalid_a(rvalid_a_rr), .rvalid_b(rvalid_b_rr),
        .busy(busy_rr), .err_a(err_a_rr), .err_b(err_b_rr));

    alu_share_arbiter #(.WIDTH(W), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst(rst),
        .req_a(req_a), .sel_a(sel_a), .opa_a(opa_a), .opb_a(opb_a),
        .req_b(req_b), .sel_b(sel_b), .opa_b(opa_b), .opb_b(opb_b),
        .gnt_a(gnt_a_fp), .gnt_b(gnt_b_fp), .alusel(alusel_fp), .op1(op1_fp), .op2(op2_fp),
        .aluout(aluout_fp), .result(result_fp), .rvalid_a(rvalid_a_fp), .rvalid_b(rvalid_b_fp),
        .busy(busy_fp), .err_a(err_a_fp), .err_b(err_b_fp));

    logic [105:0] outs_rr, outs_fp;
    assign outs_rr = {gnt_a_rr, gnt_b_rr, busy_rr, alusel_rr, op1_rr, op2_rr, result_rr,
                      rvalid_a_rr, rvalid_b_rr, err_a_rr, err_b_rr};
    assign outs_fp = {gnt_a_fp, gnt_b_fp, busy_fp, alusel_fp, op1_fp, op2_fp, result_fp,
                      rvalid_a_fp, rvalid_b_fp, err_a_fp, err_b_fp};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        tick();
        tick();
        rst   = 1'b0;
    endtask

    typedef struct {
        logic         side;   // 0: requester A, 1: requester B
        logic [2:0]   sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
    } vec_t;

    vec_t vecs [8];

    // Random-phase model state
    logic         pend [2];
    logic [2:0]   psel [2];
    logic [W-1:0] pa [2];
    logic [W-1:0] pb [2];
    logic         m_exec, m_last, m_side, win, ill;
    logic [2:0]   m_sel;
    logic [W-1:0] m_a, m_b;
    logic         e_ga, e_gb, e_busy, e_rva, e_rvb, e_ea, e_eb, e_known;
    logic [2:0]   e_alusel;
    logic [W-1:0] e_op1, e_op2, e_res;

    initial begin
        vecs[0] = '{1'b0, 3'b011, 32'd5,          32'd7,          32'd12};
        vecs[1] = '{1'b1, 3'b010, 32'd3,          32'd5,          32'hFFFF_FFFE};
        vecs[2] = '{1'b0, 3'b000, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000};
        vecs[3] = '{1'b1, 3'b001, 32'h0000_00F0,  32'h0F00_0000,  32'h0F00_00F0};
        vecs[4] = '{1'b0, 3'b100, 32'd1,          32'd31,         32'h8000_0000};
        vecs[5] = '{1'b1, 3'b100, 32'd3,          32'd4,          32'd48};
        vecs[6] = '{1'b0, 3'b101, 32'h8000_0000,  32'd4,          32'hF800_0000};
        vecs[7] = '{1'b1, 3'b101, 32'h0000_0040,  32'd3,          32'd8};

        rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
        sel_a = 3'b000; sel_b = 3'b000;
        opa_a = '0; opb_a = '0; opa_b = '0; opb_b = '0;
        tick();
        tick();
        chk("reset_rr", outs_rr, 128'd0);
        chk("reset_fp", outs_fp, 128'd0);
        rst = 1'b0;

        // Single operations from the table: grant at +1, result at +2, held afterwards.
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].side == 1'b0) begin
                req_a = 1'b1; sel_a = vecs[i].sel; opa_a = vecs[i].a; opb_a = vecs[i].b;
            end else begin
                req_b = 1'b1; sel_b = vecs[i].sel; opa_b = vecs[i].a; opb_b = vecs[i].b;
            end
            tick();
            chk($sformatf("vec%0d_gnt", i), {gnt_a_rr, gnt_b_rr, busy_rr}, {~vecs[i].side, vecs[i].side, 1'b1});
            chk($sformatf("vec%0d_alusel", i), alusel_rr, vecs[i].sel);
            chk($sformatf("vec%0d_ops", i), {op1_rr, op2_rr}, {vecs[i].a, vecs[i].b});
            req_a = 1'b0; req_b = 1'b0;
            tick();
            chk($sformatf("vec%0d_rvalid", i), {rvalid_a_rr, rvalid_b_rr, gnt_a_rr, gnt_b_rr, busy_rr},
                {~vecs[i].side, vecs[i].side, 3'b000});
            chk($sformatf("vec%0d_result", i), result_rr, vecs[i].res);
            tick();
            chk($sformatf("vec%0d_hold", i), {rvalid_a_rr, rvalid_b_rr, result_rr}, {2'b00, vecs[i].res});
        end

        // Both requests held: rr alternates A,B; fp serves A only.
        do_reset();
        req_a = 1'b1; sel_a = 3'b011; opa_a = 32'd1; opb_a = 32'd2;
        req_b = 1'b1; sel_b = 3'b001; opa_b = 32'd4; opb_b = 32'd8;
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk($sformatf("b2b_rr_c%0d", c), {gnt_a_rr, gnt_b_rr, rvalid_a_rr, rvalid_b_rr},
                {(c % 4 == 1), (c % 4 == 3), (c % 4 == 2), (c % 4 == 0)});
            chk($sformatf("b2b_fp_c%0d", c), {gnt_a_fp, gnt_b_fp, rvalid_a_fp, rvalid_b_fp},
                {(c % 2 == 1), 1'b0, (c % 2 == 0), 1'b0});
            if (c % 4 == 2) chk($sformatf("b2b_res_a_c%0d", c), result_rr, 32'd3);
            if (c % 4 == 0) chk($sformatf("b2b_res_b_c%0d", c), result_rr, 32'd12);
            if (c % 2 == 0) chk($sformatf("b2b_fp_res_c%0d", c), result_fp, 32'd3);
        end
        req_a = 1'b0;
        tick();
        chk("fp_b_served_gnt", {gnt_a_fp, gnt_b_fp, gnt_a_rr, gnt_b_rr}, 4'b0101);
        req_b = 1'b0;
        tick();
        chk("fp_b_served_rvalid", {rvalid_a_fp, rvalid_b_fp, rvalid_a_rr, rvalid_b_rr}, 4'b0101);
        chk("fp_b_served_result", {result_fp, result_rr}, {32'd12, 32'd12});

        // Reset during EXEC discards the operation.
        req_a = 1'b1; sel_a = 3'b011; opa_a = 32'd5; opb_a = 32'd7;
        tick();
        chk("rstmid_gnt", {gnt_a_rr, busy_rr}, 2'b11);
        rst = 1'b1; req_a = 1'b0;
        tick();
        chk("rstmid_zero", outs_rr, 128'd0);
        rst = 1'b0;
        tick();
        chk("rstmid_no_rvalid", outs_rr, 128'd0);
        req_a = 1'b1; sel_a = 3'b011; opa_a = 32'd9; opb_a = 32'd1;
        tick();
        chk("rstmid_next_gnt", {gnt_a_rr, gnt_b_rr}, 2'b10);
        req_a = 1'b0;
        tick();
        chk("rstmid_next_res", {rvalid_a_rr, result_rr}, {1'b1, 32'd10});

        // Illegal opcode 111.
        req_a = 1'b1; sel_a = 3'b111; opa_a = 32'd6; opb_a = 32'd7;
        tick();
        chk("illop_gnt", gnt_a_rr, 1'b1);
        chk("illop_alusel", alusel_rr, OPCHK ? 3'b011 : 3'b111);
        req_a = 1'b0;
        tick();
        chk("illop_flags", {rvalid_a_rr, err_a_rr, err_b_rr}, {1'b1, OPCHK, 1'b0});
`ifdef ALU_ARB_OPCHK_EN
        chk("illop_result", result_rr, 32'd0);
`endif
        req_a = 1'b1; sel_a = 3'b011; opa_a = 32'd2; opb_a = 32'd2;
        tick();
        req_a = 1'b0;
        tick();
        chk("illop_next", {rvalid_a_rr, err_a_rr, result_rr}, {2'b10, 32'd4});

        // Randomized traffic against a schedule-based model of the rr instance.
        do_reset();
        for (int s = 0; s < 2; s++) begin
            pend[s] = 1'b0; psel[s] = 3'b000; pa[s] = '0; pb[s] = '0;
        end
        m_exec = 1'b0; m_last = 1'b1; m_side = 1'b0; m_sel = 3'b000; m_a = '0; m_b = '0;
        e_alusel = 3'b000; e_op1 = '0; e_op2 = '0; e_res = '0; e_known = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int s = 0; s < 2; s++) begin
                if (m_exec && (int'(m_side) == s)) pend[s] = 1'b0;
                if (pend[s]) begin
                    if ($urandom_range(0, 15) == 0) pend[s] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    pend[s] = 1'b1;
                    psel[s] = 3'($urandom_range(0, 7));
                    pa[s]   = $urandom;
                    pb[s]   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
                end
            end
            req_a = pend[0]; sel_a = psel[0]; opa_a = pa[0]; opb_a = pb[0];
            req_b = pend[1]; sel_b = psel[1]; opa_b = pa[1]; opb_b = pb[1];

            e_ga = 1'b0; e_gb = 1'b0; e_busy = 1'b0; e_rva = 1'b0; e_rvb = 1'b0; e_ea = 1'b0; e_eb = 1'b0;
            if (m_exec) begin
                ill = (m_sel >= 3'd6);
                if (m_side == 1'b0) e_rva = 1'b1; else e_rvb = 1'b1;
                if (OPCHK) begin
                    if (m_side == 1'b0) e_ea = ill; else e_eb = ill;
                    e_res = ill ? 32'd0 : alu_fn(m_sel, m_a, m_b);
                    e_known = 1'b1;
                end else if (ill) begin
                    e_known = 1'b0;
                end else begin
                    e_res = alu_fn(m_sel, m_a, m_b);
                    e_known = 1'b1;
                end
                m_exec = 1'b0;
            end else if (pend[0] || pend[1]) begin
                if (pend[0] && pend[1]) win = ~m_last;
                else win = pend[0] ? 1'b0 : 1'b1;
                m_side = win; m_sel = psel[win]; m_a = pa[win]; m_b = pb[win];
                e_alusel = (OPCHK && (m_sel >= 3'd6)) ? 3'd3 : m_sel;
                e_op1 = m_a; e_op2 = m_b;
                if (win == 1'b0) e_ga = 1'b1; else e_gb = 1'b1;
                e_busy = 1'b1;
                m_last = win;
                m_exec = 1'b1;
            end
            tick();
            chk($sformatf("rand%0d_ctl", cyc),
                {gnt_a_rr, gnt_b_rr, busy_rr, alusel_rr, op1_rr, op2_rr, rvalid_a_rr, rvalid_b_rr, err_a_rr, err_b_rr},
                {e_ga, e_gb, e_busy, e_alusel, e_op1, e_op2, e_rva, e_rvb, e_ea, e_eb});
            if (e_known) chk($sformatf("rand%0d_result", cyc), result_rr, e_res);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
